// File: rtl/vgacon_term_ctrl.sv
// Terminal-style write controller for the VGA console text buffer: cursor tracking,
// control-code handling, line wrap, scroll-by-row-copy and optional vblank-gated writes.
module vgacon_term_ctrl #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 10,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  input  logic              clear,
  input  logic              vblank,
  input  logic              gate_en,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  output logic              buf_we,
  input  logic [7:0]        buf_rdata,
  output logic [1:0]        cursor_row,
  output logic [3:0]        cursor_col,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_PUT, S_SCR_RD, S_SCR_WR, S_SCR_CLR, S_CLEAR
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(NUM_ROWS * NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((NUM_ROWS - 1) * NUM_COLS);
  localparam logic [ADDR_W-1:0] ROW1_BASE     = ADDR_W'(NUM_COLS);
  localparam logic [1:0]        LAST_ROW      = 2'(NUM_ROWS - 1);
  localparam logic [3:0]        LAST_COL      = 4'(NUM_COLS - 1);

  state_e            state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [3:0]        col_q, col_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [7:0]        cap_q, cap_d;
  logic [7:0]        byte_q, byte_d;

  logic              wr_ok;
  logic              do_newline;
  logic              we_raw;
  logic [ADDR_W-1:0] cur_cell;
  logic [6:0]        code;

  assign wr_ok    = ~gate_en | vblank;
  assign code     = char_data[6:0];
  assign cur_cell = ADDR_W'(row_q) * ADDR_W'(NUM_COLS) + ADDR_W'(col_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      row_q   <= '0;
      col_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      cap_q   <= 8'h20;
      byte_q  <= 8'h20;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cap_q   <= cap_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cap_d      = cap_q;
    byte_d     = byte_q;
    do_newline = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear || (char_valid && code == 7'h0C)) begin
          // clear beats a simultaneous byte; FF takes the same path once accepted
          state_d = S_CLEAR;
          row_d   = '0;
          col_d   = '0;
          dst_d   = '0;
        end else if (char_valid) begin
          byte_d = char_data;
          if (code == 7'h0D) begin
            col_d = '0;
          end else if (code == 7'h0A) begin
            col_d      = '0;
            do_newline = 1'b1;
          end else if (code == 7'h08) begin
            if (col_q != '0) col_d = col_q - 4'd1;
          end else if (code >= 7'h20 && code <= 7'h7E) begin
            state_d = S_PUT;
          end
        end
      end
      S_PUT: begin
        if (wr_ok) begin
          state_d = S_IDLE;
          if (col_q != LAST_COL) begin
            col_d = col_q + 4'd1;
          end else begin
            col_d      = '0;
            do_newline = 1'b1;
          end
        end
      end
      S_SCR_RD: begin
        cap_d   = buf_rdata;
        state_d = S_SCR_WR;
      end
      S_SCR_WR: begin
        if (wr_ok) begin
          src_d   = src_q + 1'b1;
          dst_d   = dst_q + 1'b1;
          state_d = S_SCR_RD;
          if (src_q == LAST_CELL) begin
            dst_d   = LAST_ROW_BASE;
            state_d = S_SCR_CLR;
          end
        end
      end
      S_SCR_CLR: begin
        if (wr_ok) begin
          dst_d = dst_q + 1'b1;
          if (dst_q == LAST_CELL) state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (wr_ok) begin
          dst_d = dst_q + 1'b1;
          if (dst_q == LAST_CELL) begin
            state_d = S_IDLE;
            row_d   = '0;
            col_d   = '0;
            dst_d   = '0;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase

    // Bottom row: keep the cursor there and shift rows 1.. up by one
    if (do_newline) begin
      if (row_q != LAST_ROW) begin
        row_d = row_q + 2'd1;
      end else begin
        state_d = S_SCR_RD;
        src_d   = ROW1_BASE;
        dst_d   = '0;
      end
    end
  end

  always_comb begin
    we_raw    = 1'b0;
    buf_addr  = dst_q;
    buf_wdata = 8'h20;
    case (state_q)
      S_PUT: begin
        buf_addr  = cur_cell;
        buf_wdata = byte_q;
        we_raw    = wr_ok;
      end
      S_SCR_RD:  buf_addr = src_q;
      S_SCR_WR: begin
        buf_wdata = cap_q;
        we_raw    = wr_ok;
      end
      S_SCR_CLR: we_raw = wr_ok;
      S_CLEAR:   we_raw = wr_ok;
      default:   we_raw = 1'b0;
    endcase
  end

  // The CLEAR reset state would otherwise strobe the buffer while reset is held
  assign buf_we     = we_raw & rst_n;
  assign char_ready = (state_q == S_IDLE) & ~clear;
  assign busy       = (state_q != S_IDLE);
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_vgacon_term_ctrl.sv
// Randomized scoreboard bench for vgacon_term_ctrl: a screen/cursor model predicts every
// buffer write in order; a negedge monitor pops and compares each write the DUT issues.
module tb_vgacon_term_ctrl;
  localparam int NR = 3, NC = 10, AW = 5, CELLS = NR * NC;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          char_valid = 1'b0, clear = 1'b0, vblank = 1'b0, gate_en = 1'b0;
  logic [7:0]    char_data = 8'h00;
  logic          char_ready, buf_we, busy;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_wdata, buf_rdata;
  logic [1:0]    cursor_row;
  logic [3:0]    cursor_col;

  int total = 0, bad = 0;
  logic [7:0]  mem   [0:31];
  logic [7:0]  model [0:CELLS-1];
  int          mr = 0, mc = 0;
  logic [12:0] exp_q [$];
  logic [12:0] mon_e;
  bit          toggle_vb = 1'b0;

  always #5 clk = ~clk;

  vgacon_term_ctrl #(.NUM_ROWS(NR), .NUM_COLS(NC), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .clear(clear), .vblank(vblank), .gate_en(gate_en),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we), .buf_rdata(buf_rdata),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  // Text buffer: combinational read, synchronous write
  assign buf_rdata = mem[buf_addr];
  always @(posedge clk) if (buf_we) mem[buf_addr] <= buf_wdata;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one line per buffer write
  always @(negedge clk) begin
    if (rst_n && buf_we) begin
      if (gate_en) check("gated_write_outside_vblank", int'(vblank), 1);
      check("write_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        $display("write addr=%0d data=0x%02h (exp addr=%0d data=0x%02h)",
                 buf_addr, buf_wdata, mon_e[12:8], mon_e[7:0]);
        check("write_addr", int'(buf_addr), int'(mon_e[12:8]));
        check("write_data", int'(buf_wdata), int'(mon_e[7:0]));
      end
    end
  end

  // Random vblank while gating is being exercised
  initial forever begin
    @(posedge clk);
    #1;
    if (toggle_vb) vblank = 1'($urandom_range(0, 1));
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  task automatic push_wr(input int a, input logic [7:0] d);
    exp_q.push_back({5'(a), d});
  endtask

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) begin
      push_wr(i, 8'h20);
      model[i] = 8'h20;
    end
    mr = 0;
    mc = 0;
  endtask

  task automatic model_newline();
    if (mr < NR - 1) begin
      mr++;
    end else begin
      for (int i = 0; i < CELLS - NC; i++) begin
        push_wr(i, model[i + NC]);
        model[i] = model[i + NC];
      end
      for (int i = CELLS - NC; i < CELLS; i++) begin
        push_wr(i, 8'h20);
        model[i] = 8'h20;
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [6:0] c;
    c = b[6:0];
    if (c == 7'h0D) mc = 0;
    else if (c == 7'h0A) begin
      mc = 0;
      model_newline();
    end else if (c == 7'h08) begin
      if (mc > 0) mc--;
    end else if (c == 7'h0C) model_clear();
    else if (c >= 7'h20 && c <= 7'h7E) begin
      push_wr(mr * NC + mc, b);
      model[mr * NC + mc] = b;
      mc++;
      if (mc == NC) begin
        mc = 0;
        model_newline();
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!char_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("send_ready_timeout", int'(n < 3000), 1);
    char_valid = 1'b1;
    char_data  = b;
    model_byte(b);
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic wait_idle(input int exp_cycles, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_idle_timeout"}, int'(n < 3000), 1);
    if (exp_cycles >= 0) check({tag, "_busy_cycles"}, n, exp_cycles);
    check({tag, "_row"}, int'(cursor_row), mr);
    check({tag, "_col"}, int'(cursor_col), mc);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    check({tag, "_ready"}, int'(char_ready), 1);
  endtask

  task automatic check_screen(input string tag);
    for (int i = 0; i < CELLS; i++)
      check($sformatf("%s_cell%0d", tag, i), int'(mem[i]), int'(model[i]));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, int'(buf_we), 0);
    check({tag, "_addr"}, int'(buf_addr), 0);
    check({tag, "_wdata"}, int'(buf_wdata), 8'h20);
    check({tag, "_ready"}, int'(char_ready), 0);
    check({tag, "_busy"}, int'(busy), 1);
    check({tag, "_row"}, int'(cursor_row), 0);
    check({tag, "_col"}, int'(cursor_col), 0);
  endtask

  initial begin
    int sel;
    logic [7:0] b;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));

    // Reset and automatic clear
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    model_clear();
    rst_n = 1'b1;
    wait_idle(30, "post_reset_clear");
    check_screen("post_reset");

    // Two bytes, first written one cycle after acceptance
    send(8'h41);
    @(negedge clk);
    check("put_latency_we", int'(buf_we), 1);
    check("put_latency_addr", int'(buf_addr), 0);
    send(8'hC2);
    wait_idle(-1, "two_bytes");
    check_screen("two_bytes");

    // FF, then a full row wraps; BS and CR at column 0
    send(8'h0C);
    wait_idle(30, "ff");
    for (int i = 0; i < NC; i++) begin
      send(8'h61 + 8'(i));
      wait_idle(1, "row_fill");
    end
    send(8'h08);
    wait_idle(0, "bs_col0");
    send(8'h0D);
    wait_idle(0, "cr_col0");

    // Fill the screen to (2,9), then the wrapping byte triggers the scroll
    send(8'h0C);
    wait_idle(30, "ff2");
    for (int i = 0; i < CELLS - 1; i++) begin
      send(8'h21 + 8'(i));
      wait_idle(1, "screen_fill");
    end
    send(8'h5A);
    wait_idle(51, "scroll");
    check_screen("scroll");

    // Gated write waits for vblank
    gate_en = 1'b1;
    vblank  = 1'b0;
    send(8'h41);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gated_hold_we", int'(buf_we), 0);
      check("gated_hold_busy", int'(busy), 1);
    end
    @(posedge clk);
    #1 vblank = 1'b1;
    @(negedge clk);
    check("vblank_first_cycle_we", int'(buf_we), 1);
    wait_idle(-1, "gated_put");

    // Gated scroll with vblank toggling
    toggle_vb = 1'b1;
    for (int i = 0; i < NC - 1; i++) begin
      send(8'h50 + 8'(i));
      wait_idle(-1, "gated_scroll");
    end
    toggle_vb = 1'b0;
    gate_en   = 1'b0;
    vblank    = 1'b0;
    check_screen("gated_scroll");

    // clear together with a byte: clear wins, byte not taken
    @(negedge clk);
    clear = 1'b1;
    char_valid = 1'b1;
    char_data = 8'h41;
    #1 check("ready_during_clear", int'(char_ready), 0);
    model_clear();
    @(posedge clk);
    #1;
    clear = 1'b0;
    char_valid = 1'b0;
    wait_idle(30, "clear_req");
    check_screen("clear_req");

    // Reset in the middle of a scroll
    send(8'h0A);
    wait_idle(0, "lf1");
    send(8'h0A);
    wait_idle(0, "lf2");
    send(8'h0A);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_vals("mid_scroll_reset");
    @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1;
    wait_idle(30, "rerun_clear");
    check_screen("rerun_clear");

    // Randomized stream
    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 99);
      if (sel < 60) b = {1'($urandom_range(0, 1)), 7'($urandom_range(32, 126))};
      else if (sel < 70) b = 8'h0A;
      else if (sel < 78) b = 8'h0D;
      else if (sel < 86) b = 8'h08;
      else if (sel < 88) b = 8'h0C;
      else b = 8'($urandom_range(0, 255));
      if (k % 50 == 25) begin
        gate_en = 1'b1;
        toggle_vb = 1'b1;
      end
      if (k % 50 == 45) begin
        toggle_vb = 1'b0;
        gate_en = 1'b0;
        vblank = 1'b0;
      end
      send(b);
      wait_idle(-1, "rnd");
    end
    toggle_vb = 1'b0;
    gate_en = 1'b0;
    check_screen("rnd_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
